// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_fifoed_send channel between NREQ byte-stream requesters.
// Packets stay atomic on the wire, with an optional tag byte, almost-full throttling and a stall timeout.
module uart_tx_arbiter #(
  parameter int          NREQ     = 4,
  parameter bit          TAG_EN   = 1'b1,
  parameter logic [7:0]  TAG_BASE = 8'hF0,
  parameter int          TIMEOUT  = 1000
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_afull,
  output logic              dat_en,
  output logic [7:0]        dat,
  output logic              grant_valid,
  output logic [2:0]        grant_id,
  output logic              timeout_pulse
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

  state_t          state_q, state_d;
  logic            dat_en_q, dat_en_d;
  logic [7:0]      dat_q, dat_d;
  logic            grant_valid_q, grant_valid_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic            timeout_pulse_q, timeout_pulse_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic [IW-1:0]   gidx;
  logic            cur_valid, cur_last, xfer, stall;
  logic [7:0]      cur_data;
  logic            sel_found;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   idx;

  assign gidx      = grant_id_q[IW-1:0];
  assign cur_valid = req_valid[gidx];
  assign cur_last  = req_last[gidx];
  assign cur_data  = req_data[{gidx, 3'b000} +: 8];
  assign xfer      = (state_q == DATA) && cur_valid && !fifo_afull;
  assign stall     = (state_q == DATA) && !cur_valid && !fifo_afull;

  always_comb begin
    req_ready       = '0;
    req_ready[gidx] = xfer;
  end

  // Search starts just after the previous winner so a finishing requester yields to any other pending one.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant_q) + k) % NREQ);
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    dat_en_d        = 1'b0;
    dat_d           = dat_q;
    grant_valid_d   = grant_valid_q;
    grant_id_d      = grant_id_q;
    timeout_pulse_d = 1'b0;
    last_grant_d    = last_grant_q;
    stall_cnt_d     = stall_cnt_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (sel_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = 3'(sel_id);
          last_grant_d  = sel_id;
          state_d       = TAG_EN ? TAG : DATA;
        end
      end
      TAG: begin
        if (!fifo_afull) begin
          dat_en_d = 1'b1;
          dat_d    = TAG_BASE + 8'(grant_id_q);
          state_d  = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          dat_en_d    = 1'b1;
          dat_d       = cur_data;
          stall_cnt_d = '0;
          if (cur_last) begin
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end else if (stall) begin
          // Only requester-side stalls count; afull waits are the sender's fault, not the requester's.
          if (stall_cnt_q == CW'(TIMEOUT - 1)) begin
            grant_valid_d   = 1'b0;
            timeout_pulse_d = 1'b1;
            stall_cnt_d     = '0;
            state_d         = IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      dat_en_q        <= 1'b0;
      dat_q           <= 8'h00;
      grant_valid_q   <= 1'b0;
      grant_id_q      <= 3'd0;
      timeout_pulse_q <= 1'b0;
      last_grant_q    <= IW'(NREQ - 1);
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      dat_en_q        <= dat_en_d;
      dat_q           <= dat_d;
      grant_valid_q   <= grant_valid_d;
      grant_id_q      <= grant_id_d;
      timeout_pulse_q <= timeout_pulse_d;
      last_grant_q    <= last_grant_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign dat_en        = dat_en_q;
  assign dat           = dat_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one `uart_fifoed_send` transmit channel between NREQ independent byte-stream requesters.
- Each requester offers packets: a byte stream whose final byte carries a `last` flag.
- The block grants packets round-robin and keeps each packet atomic on the wire.
- It optionally prefixes each packet with a channel tag byte, throttles on the sender's almost-full flag, and drops the grant of a requester that stalls mid-packet.
- It sits between the CPU-side debug/console sources and the `dat_en`/`dat` inputs of `uart_fifoed_send`.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- TAG_EN, 1: 1 = emit a tag byte before each packet; 0 = no tag.
- TAG_BASE, 8'hF0: tag byte value is TAG_BASE + requester index, modulo 256.
- TIMEOUT, 1000: number of consecutive stalled cycles inside a granted packet before the grant is forcibly released.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i].
- req_last  in  NREQ  current byte is the last byte of its packet.
- req_ready  out  NREQ  byte of requester i is accepted this cycle.
- fifo_afull  in  1  almost-full flag from the sender.
- dat_en  out  1  push strobe to the sender FIFO.
- dat  out  8  byte pushed to the sender FIFO.
- grant_valid  out  1  a packet is in progress.
- grant_id  out  3  index of the granted requester; valid while grant_valid=1.
- timeout_pulse  out  1  one-cycle pulse when a grant is dropped by timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; dat_en=0; dat=0; grant_valid=0; grant_id=0; timeout_pulse=0.
  - Internal last_grant=NREQ-1, so requester 0 has first priority.
  - Stall counter = 0.
- State machine:
  - IDLE:
    - If any req_valid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
    - Load grant_id, set grant_valid=1, last_grant <= selected index.
    - Go to TAG if TAG_EN=1, else to DATA.
    - No byte is accepted in the cycle the grant is made.
  - TAG:
    - When fifo_afull=0: register dat_en=1 and dat=TAG_BASE+grant_id, then go to DATA.
    - Otherwise hold in TAG.
  - DATA:
    - req_ready[grant_id] = req_valid[grant_id] & ~fifo_afull. This is combinational; all other req_ready bits are 0.
    - On a transfer, next cycle dat_en=1 and dat=the accepted byte. Latency is exactly 1 cycle.
    - A transfer with req_last=1 returns to IDLE and clears grant_valid.
- req_ready is 0 in IDLE and TAG.
- dat_en is 0 in every cycle that follows a cycle with no push decision.
- Backpressure:
  - fifo_afull is sampled in the same cycle as the push decision.
  - At most one byte is in flight when afull rises. The sender's afull margin of 6 entries guarantees the sender FIFO never overflows.
  - fifo_full is not used.
- Timeout:
  - In DATA, the stall counter increments on each cycle with req_valid[grant_id]=0 and fifo_afull=0. It clears on any transfer.
  - When the counter reaches TIMEOUT-1 and the stall continues: go to IDLE, clear grant_valid, pulse timeout_pulse for 1 cycle, reset the counter.
  - The partial packet stays on the wire; no terminator is inserted.
  - Cycles stalled by fifo_afull never count toward the timeout.
- Fairness:
  - A requester that has just finished cannot be regranted while another requester is valid in the IDLE cycle.
  - A new grant costs 1 IDLE cycle, plus 1 TAG cycle when TAG_EN=1.
- Simultaneous events:
  - A valid byte with last=1 arriving on the timeout cycle is accepted; the timeout does not fire.
  - A requester deasserting valid while in IDLE is simply not selected.
- grant_id is a 3-bit field; with NREQ<8, only values 0..NREQ-1 occur.
- Asynchronous reset mid-packet:
  - Abandons the packet immediately and forces all outputs to their reset values.
  - A dat_en pulse in that cycle is lost.

Test Plan:
1. Reset released, requester 1 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), TAG_EN=1, afull=0 -> dat_en stream 0xF1, 0x41, 0x42, 0x43 on 4 consecutive cycles. grant_valid high from the grant cycle until the cycle after last. grant_id=1.
2. All 4 requesters continuously valid with 2-byte packets -> tag order 0xF0, 0xF1, 0xF2, 0xF3, 0xF0; each packet contiguous and never interleaved.
3. Requester 0 mid-packet, fifo_afull held high for 50 cycles -> req_ready=0 and dat_en=0 throughout, no timeout_pulse. Transfer resumes in the cycle afull falls.
4. TIMEOUT=16, requester 2 sends 1 byte without last, then drops valid -> timeout_pulse after 16 stalled cycles, grant_valid=0. Requester 3, pending meanwhile, is granted next with tag 0xF3.
5. reset=0 asserted asynchronously during byte 2 of a packet -> dat_en, grant_valid and req_ready are all 0 immediately. After release, requester 0 is granted first.
6. TAG_EN=0, single requester with a 1-byte packet (last=1) -> exactly one dat_en pulse carrying the byte, 2 cycles after req_valid rises.
